// File: rtl/seq_shift_add_mult_if.sv
// seq_shift_add_mult_if: start/ready/done handshake and operand/result bus for the shift-add multiplier
interface seq_shift_add_mult_if #(parameter int WIDTH = 4);
  localparam int CNT_W = $clog2(WIDTH + 1);
  logic               start;
  logic               signed_mode;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               done;
  logic [CNT_W-1:0]   busy_cnt;
  logic [2*WIDTH-1:0] product;
  modport master (output start, signed_mode, a, b, input ready, done, busy_cnt, product);
  modport slave (input start, signed_mode, a, b, output ready, done, busy_cnt, product);
endinterface

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult: sequential shift-add multiplier, unsigned or two's-complement, one bit per cycle
module seq_shift_add_mult #(parameter int WIDTH = 4) (
  input logic clk,
  input logic rst_n,
  seq_shift_add_mult_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic               r_mode;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_done;
  logic [WIDTH-1:0]   w_hi;
  logic [WIDTH:0]     w_hi_x;
  logic [WIDTH:0]     w_add;
  logic [WIDTH:0]     w_sum;
  logic               w_last;
  assign w_hi   = r_prod[2*WIDTH-1:WIDTH];
  assign w_hi_x = {r_mode & w_hi[WIDTH-1], w_hi};
  assign w_add  = r_prod[0] ? {r_mode & r_mcand[WIDTH-1], r_mcand} : '0;
  assign w_last = r_cnt == CNT_W'(1);
  // the multiplier sign bit carries negative weight, so the last signed step subtracts
  assign w_sum  = (w_last && r_mode) ? w_hi_x - w_add : w_hi_x + w_add;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_mcand <= '0;
      r_mode  <= 1'b0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == IDLE) begin
        if (bus.start) begin
          r_mcand <= bus.a;
          r_mode  <= bus.signed_mode;
          r_prod  <= {{WIDTH{1'b0}}, bus.b};
          r_cnt   <= CNT_W'(WIDTH);
          r_state <= RUN;
        end
      end else begin
        r_prod <= {w_sum, r_prod[WIDTH-1:1]};
        r_cnt  <= r_cnt - 1'b1;
        if (w_last) begin
          r_state <= IDLE;
          r_done  <= 1'b1;
        end
      end
    end
  end
  assign bus.ready    = r_state == IDLE;
  assign bus.done     = r_done;
  assign bus.busy_cnt = r_cnt;
  assign bus.product  = r_prod;
endmodule

// File: tb/tb_seq_shift_add_mult.sv
// tb_seq_shift_add_mult: scoreboard bench for 4- and 8-bit multiplier instances
module tb_seq_shift_add_mult;
  typedef struct {logic [15:0] p; longint c;} exp_t;
  logic   clk = 1'b0;
  logic   rst_n = 1'b0;
  longint cyc = 0;
  int     n_err = 0;
  int     n_chk = 0;
  exp_t   q4[$];
  exp_t   q8[$];
  exp_t   e4;
  exp_t   e8;
  seq_shift_add_mult_if #(.WIDTH(4)) if4();
  seq_shift_add_mult_if #(.WIDTH(8)) if8();
  seq_shift_add_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_shift_add_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] model(input logic sm, input logic [7:0] a, input logic [7:0] b, input int w);
    longint av = longint'(a);
    longint bv = longint'(b);
    longint mask = (longint'(1) << (2 * w)) - 1;
    if (sm && a[w-1]) av = av - (longint'(1) << w);
    if (sm && b[w-1]) bv = bv - (longint'(1) << w);
    return 16'((av * bv) & mask);
  endfunction
  always @(negedge clk) if (if4.done) begin
    if (q4.size() == 0) check("done4_spurious", 1, 0);
    else begin
      e4 = q4.pop_front();
      check("prod4", if4.product, e4.p);
      check("lat4", cyc, e4.c);
      check("rdy4_at_done", if4.ready, 1);
    end
  end
  always @(negedge clk) if (if8.done) begin
    if (q8.size() == 0) check("done8_spurious", 1, 0);
    else begin
      e8 = q8.pop_front();
      check("prod8", if8.product, e8.p);
      check("lat8", cyc, e8.c);
    end
  end
  task automatic op4(input logic sm, input logic [3:0] a, input logic [3:0] b, input logic [7:0] exp);
    int t = 0;
    while (!if4.ready && t < 50) begin @(negedge clk); t++; end
    check("op4_ready", if4.ready, 1);
    if4.a = a; if4.b = b; if4.signed_mode = sm; if4.start = 1'b1;
    q4.push_back('{16'(exp), cyc + 5});
    @(negedge clk);
    if4.start = 1'b0;
  endtask
  task automatic op8(input logic sm, input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    int t = 0;
    while (!if8.ready && t < 50) begin @(negedge clk); t++; end
    check("op8_ready", if8.ready, 1);
    if8.a = a; if8.b = b; if8.signed_mode = sm; if8.start = 1'b1;
    q8.push_back('{exp, cyc + 9});
    @(negedge clk);
    if8.start = 1'b0;
  endtask
  task automatic wait_idle4();
    int t = 0;
    @(negedge clk);
    while (!if4.ready && t < 50) begin @(negedge clk); t++; end
    check("idle4_timeout", if4.ready, 1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [3:0] ra, rb;
    logic [7:0] sa, sb;
    logic       rs;
    if4.start = 0; if4.signed_mode = 0; if4.a = 0; if4.b = 0;
    if8.start = 0; if8.signed_mode = 0; if8.a = 0; if8.b = 0;
    repeat (2) @(negedge clk);
    check("rst_ready", if4.ready, 1);
    check("rst_done", if4.done, 0);
    check("rst_cnt", if4.busy_cnt, 0);
    check("rst_prod", if4.product, 0);
    check("rst_prod8", if8.product, 0);
    rst_n = 1'b1;
    @(negedge clk);
    // 15*15 with busy_cnt trace
    if4.a = 4'hF; if4.b = 4'hF; if4.signed_mode = 0; if4.start = 1'b1;
    q4.push_back('{16'h00E1, cyc + 5});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if4.start = 1'b0;
      check("t1_cnt", if4.busy_cnt, 4 - i);
      check("t1_busy", if4.ready, 0);
    end
    @(negedge clk);
    check("t1_cnt_end", if4.busy_cnt, 0);
    check("t1_done", if4.done, 1);
    check("t1_ready", if4.ready, 1);
    // signed corner cases
    op4(1, 4'h8, 4'h7, 8'hC8);
    op4(1, 4'h8, 4'h8, 8'h40);
    op4(1, 4'hF, 4'h1, 8'hFF);
    wait_idle4();
    repeat (3) @(negedge clk);
    check("t2_hold", if4.product, 8'hFF);
    // back-to-back with start held high
    if4.a = 4'd3; if4.b = 4'd5; if4.signed_mode = 0; if4.start = 1'b1;
    q4.push_back('{16'h000F, cyc + 5});
    repeat (5) @(negedge clk);
    check("t3_done1", if4.done, 1);
    check("t3_prod1", if4.product, 8'h0F);
    if4.a = 4'hD; if4.b = 4'd5; if4.signed_mode = 1;
    q4.push_back('{16'h00F1, cyc + 5});
    @(negedge clk);
    if4.start = 1'b0;
    check("t3_busy2", if4.ready, 0);
    wait_idle4();
    check("t3_prod2", if4.product, 8'hF1);
    // mid-run operand change and ignored start
    op4(0, 4'd6, 4'd9, 8'h36);
    if4.a = 4'd1; if4.b = 4'd2; if4.signed_mode = 1; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    check("t4_ignored", if4.ready, 0);
    wait_idle4();
    repeat (6) @(negedge clk);
    check("t4_hold", if4.product, 8'h36);
    // asynchronous reset mid-run
    if4.a = 4'd5; if4.b = 4'd5; if4.signed_mode = 0; if4.start = 1'b1;
    @(negedge clk);
    if4.start = 1'b0;
    repeat (2) @(negedge clk);
    check("t5_cnt2", if4.busy_cnt, 2);
    #2 rst_n = 1'b0;
    #1;
    check("t5_ready", if4.ready, 1);
    check("t5_prod", if4.product, 0);
    check("t5_cnt", if4.busy_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    check("t5_nodone", if4.done, 0);
    op4(0, 4'd2, 4'd3, 8'h06);
    // 8-bit instance
    op8(0, 8'hFF, 8'hFF, 16'hFE01);
    op8(1, 8'h80, 8'h7F, 16'hC080);
    for (int i = 0; i < 12; i++) begin
      ra = 4'($urandom); rb = 4'($urandom); rs = 1'($urandom);
      op4(rs, ra, rb, 8'(model(rs, {4'h0, ra}, {4'h0, rb}, 4)));
      sa = 8'($urandom); sb = 8'($urandom); rs = 1'($urandom);
      op8(rs, sa, sb, model(rs, sa, sb, 8));
    end
    repeat (14) @(negedge clk);
    check("q4_drain", q4.size(), 0);
    check("q8_drain", q8.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
